mon_dump_engine: RTL and testbench

MON_DUMP_ENGINE -- requirements
Module: mon_dump_engine

---
 rtl/mon_dump_if.sv | 20 ++
 rtl/mon_dump_engine.sv | 113 +++++++++++
 tb/tb_mon_dump_engine.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/mon_dump_if.sv
// mon_dump_if: control, RAM read port and TX FIFO signals of the dump engine.
interface mon_dump_if #(
    parameter int AWIDTH = 12,
    parameter int DBYTES = 4
);
    logic              start, stop, sel;
    logic [AWIDTH-1:0] start_adr, end_adr, ram_radr;
    logic              ram_ren, ram_sel;
    logic [8*DBYTES-1:0] ram_rdata;
    logic [7:0]        tx_char;
    logic              tx_wen, tx_full, busy, done;
    modport master (
        input  start, stop, sel, start_adr, end_adr, ram_rdata, tx_full,
        output ram_radr, ram_ren, ram_sel, tx_char, tx_wen, busy, done
    );
    modport slave (
        output start, stop, sel, start_adr, end_adr, ram_rdata, tx_full,
        input  ram_radr, ram_ren, ram_sel, tx_char, tx_wen, busy, done
    );
endinterface

// File: rtl/mon_dump_engine.sv
// mon_dump_engine: streams a RAM address range as lines of lowercase hex text into a TX FIFO.
module mon_dump_engine #(
    parameter int AWIDTH = 12,
    parameter int DBYTES = 4,
    parameter int WPL    = 4,
    parameter int RLAT   = 1
) (
    input logic        clk,
    input logic        rst,
    mon_dump_if.master bus
);
    localparam int HD = (AWIDTH + 3) / 4;
    localparam int DD = 2 * DBYTES;

    typedef enum logic [3:0] {IDLE, HDR, RD, WAIT, DATA, SEP, CR, LF, FIN} state_t;
    state_t state, nxt;

    logic [AWIDTH-1:0]   adr, end_q, radr;
    logic [4*HD-1:0]     hsh;
    logic [8*DBYTES-1:0] dsh;
    logic [5:0]          idx;
    logic [4:0]          cnt;
    logic [1:0]          wcnt;
    logic                stop_q, last_q, sel_q;
    logic                go, emit, sent, hdr_end, data_end, wait_end, brk;
    logic [3:0]          nib;
    logic [7:0]          hex, chr;

    assign go       = bus.start && state == IDLE;
    assign emit     = state inside {HDR, DATA, SEP, CR, LF};
    assign sent     = emit && !bus.tx_full;
    assign hdr_end  = state == HDR && sent && idx == 6'(HD + 1);
    assign data_end = state == DATA && sent && idx == 6'(DD - 1);
    assign wait_end = wcnt == 2'(RLAT - 1);
    // a word closes its line when it is the final word, fills the line, or a stop is pending
    assign brk      = adr == end_q || cnt == 5'(WPL - 1) || stop_q;

    always_comb begin
        nib = state == HDR ? hsh[4*HD-1 -: 4] : dsh[8*DBYTES-1 -: 4];
        hex = nib < 4'd10 ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
        chr = state == HDR  ? (idx < 6'(HD) ? hex : idx == 6'(HD) ? 8'h3a : 8'h20) :
              state == DATA ? hex :
              state == SEP  ? 8'h20 :
              state == CR   ? 8'h0d :
              state == LF   ? 8'h0a : 8'h00;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = go ? HDR : IDLE;
            HDR:     nxt = hdr_end ? RD : HDR;
            RD:      nxt = WAIT;
            WAIT:    nxt = wait_end ? DATA : WAIT;
            DATA:    nxt = data_end ? (brk ? CR : SEP) : DATA;
            SEP:     nxt = sent ? (stop_q ? CR : RD) : SEP;
            CR:      nxt = sent ? LF : CR;
            LF:      nxt = sent ? ((last_q || stop_q) ? FIN : HDR) : LF;
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            adr    <= '0;
            end_q  <= '0;
            radr   <= '0;
            hsh    <= '0;
            dsh    <= '0;
            idx    <= '0;
            cnt    <= '0;
            wcnt   <= '0;
            stop_q <= 1'b0;
            last_q <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            state <= nxt;
            if (bus.stop && state != IDLE) stop_q <= 1'b1;
            if (go) begin
                adr    <= bus.start_adr;
                end_q  <= bus.end_adr < bus.start_adr ? bus.start_adr : bus.end_adr;
                hsh    <= (4*HD)'(bus.start_adr);
                sel_q  <= bus.sel;
                stop_q <= bus.stop;
                last_q <= 1'b0;
            end
            if (sent) idx <= (state == HDR && !hdr_end) || (state == DATA && !data_end) ? idx + 6'd1 : 6'd0;
            if (state == HDR) cnt <= '0;
            if (state == HDR && sent && idx < 6'(HD)) hsh <= hsh << 4;
            if (state == LF && sent) hsh <= (4*HD)'(adr);
            if (nxt == RD) radr <= adr;
            if (state == WAIT) wcnt <= wait_end ? 2'd0 : wcnt + 2'd1;
            if (state == WAIT && wait_end) dsh <= bus.ram_rdata;
            if (state == DATA && sent) dsh <= dsh << 4;
            // the address saturates at the latched end so a range ending at the top never wraps
            if (data_end) begin
                cnt <= cnt + 5'd1;
                if (adr == end_q) last_q <= 1'b1;
                else adr <= adr + 1'b1;
            end
        end
    end

    assign bus.ram_radr = rst ? '0 : radr;
    assign bus.ram_ren  = !rst && state == RD;
    assign bus.ram_sel  = !rst && sel_q;
    assign bus.tx_char  = rst ? 8'h00 : chr;
    assign bus.tx_wen   = !rst && sent;
    assign bus.busy     = !rst && state != IDLE && state != FIN;
    assign bus.done     = !rst && state == FIN;
endmodule

// File: tb/tb_mon_dump_engine.sv
// tb_mon_dump_engine: random and directed dumps checked against a text-level model of the expected stream.
module tb_mon_dump_engine;
    localparam int WPL = 4;

    logic clk, rst;
    mon_dump_if #(.AWIDTH(12), .DBYTES(4)) bus ();
    mon_dump_engine #(.AWIDTH(12), .DBYTES(4), .WPL(WPL), .RLAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [4096];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          ren_q [$];
    int          total = 0, bad = 0;
    int          wen_cnt = 0, ren_cnt = 0, done_cnt = 0;
    int          full_mode = 0;
    logic        exp_sel = 0;
    logic        prev_full = 0, prev_wen = 0;
    logic [7:0]  prev_char = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_radr];

    initial begin
        int fcyc = 0;
        bus.tx_full = 0;
        forever begin
            @(posedge clk);
            #1;
            fcyc++;
            bus.tx_full = full_mode == 0 ? 1'b0 :
                          full_mode == 1 ? 1'(((fcyc / 3) % 2) == 1) : 1'($urandom_range(0, 3) == 0);
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected text: a header per line of WPL words, words separated by blanks, each line ends CR LF.
    task automatic model(int s, int e, int nmax);
        int n;
        string t;
        exp_q.delete();
        ren_q.delete();
        if (e < s) e = s;
        n = e - s + 1;
        if (nmax > 0 && nmax < n) n = nmax;
        for (int w = 0; w < n; w++) begin
            int a = s + w;
            t = "";
            if (w % WPL == 0) t = $sformatf("%h: ", 12'(a));
            t = {t, $sformatf("%h", mem[a])};
            if (w == n - 1 || w % WPL == WPL - 1) t = {t, "\015\012"};
            else t = {t, " "};
            for (int i = 0; i < t.len(); i++) exp_q.push_back(t[i]);
            ren_q.push_back(a);
        end
    endtask

    always @(negedge clk) begin
        logic [63:0] want;
        if (!rst) begin
            if (prev_full && prev_char != 0) chk("stall_stable", bus.tx_char, prev_char);
            if (bus.tx_full && bus.tx_char != 0) chk("stall_head", bus.tx_char, exp_q.size() != 0 ? {56'h0, exp_q[0]} : 64'h100);
            if (bus.tx_wen) begin
                chk("wen_while_full", bus.tx_full, 0);
                want = exp_q.size() != 0 ? {56'h0, exp_q[0]} : 64'h100;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                chk("char", bus.tx_char, want);
                got_q.push_back(bus.tx_char);
                wen_cnt++;
            end
            if (bus.ram_ren) begin
                want = ren_q.size() != 0 ? 64'(ren_q[0]) : 64'h10000;
                if (ren_q.size() != 0) void'(ren_q.pop_front());
                chk("ram_radr", bus.ram_radr, want);
                chk("ram_sel", bus.ram_sel, exp_sel);
                ren_cnt++;
            end
            if (bus.done) begin
                chk("done_after_lf", {prev_wen, prev_char}, {1'b1, 8'h0a});
                chk("busy_at_done", bus.busy, 0);
                done_cnt++;
            end
        end
        prev_full = bus.tx_full;
        prev_char = bus.tx_char;
        prev_wen  = bus.tx_wen;
    end

    task automatic check_idle(string tag);
        chk({tag, "_radr"}, bus.ram_radr, 0);
        chk({tag, "_ren"}, bus.ram_ren, 0);
        chk({tag, "_sel"}, bus.ram_sel, 0);
        chk({tag, "_char"}, bus.tx_char, 0);
        chk({tag, "_wen"}, bus.tx_wen, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    task automatic do_start(int s, int e, logic sl, bit stop_now);
        exp_sel = sl;
        @(posedge clk);
        #1;
        bus.start = 1; bus.stop = stop_now; bus.sel = sl;
        bus.start_adr = 12'(s); bus.end_adr = 12'(e);
        @(posedge clk);
        #1;
        bus.start = 0; bus.stop = 0; bus.sel = ~sl;
        bus.start_adr = 12'($urandom); bus.end_adr = 12'($urandom);
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic run(int s, int e, logic sl, int stop_k, bit stop_now, output int g0, output int nw, output int nr);
        int w0, r0, d0;
        model(s, e, stop_now ? 1 : stop_k);
        g0 = got_q.size(); w0 = wen_cnt; r0 = ren_cnt; d0 = done_cnt;
        do_start(s, e, sl, stop_now);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1; bus.start_adr = 12'($urandom); bus.end_adr = 12'($urandom);
        @(posedge clk);
        #1;
        bus.start = 0;
        if (stop_k > 0) begin
            for (int c = 0; c < 5000 && ren_cnt - r0 < stop_k; c++) @(posedge clk);
            repeat (3) @(posedge clk);
            #1;
            bus.stop = 1;
            @(posedge clk);
            #1;
            bus.stop = 0;
        end
        for (int c = 0; c < 30000 && done_cnt == d0; c++) @(posedge clk);
        chk("done_seen", done_cnt - d0, 1);
        @(posedge clk);
        #1;
        chk("left_chars", exp_q.size(), 0);
        chk("left_reads", ren_q.size(), 0);
        chk("busy_idle", bus.busy, 0);
        nw = wen_cnt - w0;
        nr = ren_cnt - r0;
    endtask

    task automatic lit(string name, int g0, string s);
        int diff = -1;
        if (got_q.size() - g0 != s.len()) diff = -2;
        else for (int i = 0; i < s.len(); i++) if (diff < 0 && got_q[g0 + i] != s[i]) diff = i;
        chk(name, diff, -1);
    endtask

    initial begin
        int g0, nw, nr, w0, r0, d0;
        rst = 1; bus.start = 0; bus.stop = 0; bus.sel = 0; bus.start_adr = 0; bus.end_adr = 0;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 0;
        mem[16] = 32'h12345678; mem[17] = 32'hdeadbeef; mem[18] = 32'h00000001;
        run(16, 18, 0, 0, 0, g0, nw, nr);
        lit("basic_text", g0, "010: 12345678 deadbeef 00000001\015\012");
        chk("basic_wen", nw, 33);
        chk("basic_ren", nr, 3);
        full_mode = 1;
        run(16, 18, 1, 0, 0, g0, nw, nr);
        lit("bp_text", g0, "010: 12345678 deadbeef 00000001\015\012");
        chk("bp_wen", nw, 33);
        full_mode = 0;
        for (int i = 0; i < 5; i++) mem[i] = 32'(i);
        run(0, 4, 0, 0, 0, g0, nw, nr);
        lit("wrap_text", g0, "000: 00000000 00000001 00000002 00000003\015\012004: 00000004\015\012");
        chk("wrap_ren", nr, 5);
        mem[0] = 32'hcafe0000; mem[1] = 32'h0badf00d;
        run(0, 255, 1, 2, 0, g0, nw, nr);
        lit("stop_text", g0, "000: cafe0000 0badf00d\015\012");
        chk("stop_ren", nr, 2);
        mem[7] = 32'h0000abcd;
        run(7, 5, 0, 0, 0, g0, nw, nr);
        lit("rev_text", g0, "007: 0000abcd\015\012");
        mem[4095] = 32'hf00dface;
        run(4095, 4095, 0, 0, 0, g0, nw, nr);
        lit("top_text", g0, "fff: f00dface\015\012");
        chk("top_ren", nr, 1);
        full_mode = 2;
        run(4093, 4095, 1, 0, 0, g0, nw, nr);
        run(32, 60, 0, 0, 1, g0, nw, nr);
        chk("stop_start_ren", nr, 1);
        full_mode = 0;
        model(256, 263, 0);
        w0 = wen_cnt; r0 = ren_cnt; d0 = done_cnt;
        do_start(256, 263, 1, 0);
        for (int c = 0; c < 5000 && ren_cnt == r0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        exp_q.delete();
        ren_q.delete();
        @(posedge clk);
        #1;
        rst = 0;
        w0 = wen_cnt; r0 = ren_cnt;
        check_idle("rst_mid");
        repeat (40) @(posedge clk);
        #1;
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_wen", wen_cnt - w0, 0);
        chk("rst_no_ren", ren_cnt - r0, 0);
        run(16, 18, 0, 0, 0, g0, nw, nr);
        lit("after_rst_text", g0, "010: 12345678 deadbeef 00000001\015\012");
        for (int i = 0; i < 10; i++) begin
            int s = $urandom_range(0, 4095);
            int len = $urandom_range(0, 14);
            int e = $urandom_range(0, 5) == 0 ? $urandom_range(0, s) : (s + len > 4095 ? 4095 : s + len);
            full_mode = $urandom_range(0, 2);
            run(s, e, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 4) == 0, g0, nw, nr);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
